// File: rtl/aes_128_inv_key_sched.sv
// aes_128_inv_key_sched: iterative AES-128 key expansion around one S4 unit.
// Expands forward to k10, then steps backwards emitting k10..k0 on a stream.
module aes_128_inv_key_sched #(
  parameter int NR       = 10,
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         start_valid,
  output logic         start_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE, FWD_SUB, FWD_UPD, REV_SUB, REV_UPD, EMIT
  } state_t;

  localparam int CW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(SBOX_LAT - 1);
  localparam logic [3:0] LAST = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the bit base is 2047 - 8*x.
  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t        state;
  logic [127:0]  cur;
  logic [3:0]    r;
  logic [CW-1:0] cnt;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] s_in, s_out;
  logic [3:0]  r_up;
  logic [31:0] s_pipe [SBOX_LAT];

  assign {w0, w1, w2, w3} = cur;
  assign r_up = r + 4'd1;

  assign n0 = w0 ^ s_out ^ {rcon(r_up), 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign p0 = w0 ^ s_out ^ {rcon(r), 24'h0};

  // The S4 input is held constant for the whole SUB phase.
  assign s_in  = (state == REV_SUB) ? rot_word(p3) : rot_word(w3);
  assign s_out = s_pipe[SBOX_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SBOX_LAT; i++) s_pipe[i] <= '0;
    end else begin
      s_pipe[0] <= sub_word(s_in);
      for (int i = 1; i < SBOX_LAT; i++) s_pipe[i] <= s_pipe[i-1];
    end
  end

  assign start_ready = (state == IDLE) && !rst;
  assign busy        = (state != IDLE);
  assign rk          = cur;
  assign rk_round    = r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= '0;
      r        <= '0;
      cnt      <= '0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            cur   <= key;
            r     <= '0;
            cnt   <= '0;
            state <= FWD_SUB;
          end
        end
        FWD_SUB, REV_SUB: begin
          if (cnt == LAT_M1) begin
            cnt   <= '0;
            state <= (state == FWD_SUB) ? FWD_UPD : REV_UPD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FWD_UPD: begin
          cur <= {n0, n1, n2, n3};
          r   <= r_up;
          if (r_up == LAST) begin
            rk_valid <= 1'b1;
            rk_last  <= 1'b0;
            state    <= EMIT;
          end else begin
            state <= FWD_SUB;
          end
        end
        REV_UPD: begin
          cur      <= {p0, p1, p2, p3};
          r        <= r - 4'd1;
          rk_valid <= 1'b1;
          rk_last  <= (r == 4'd1);
          state    <= EMIT;
        end
        EMIT: begin
          if (rk_ready) begin
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            state    <= (r == 4'd0) ? IDLE : REV_SUB;
          end
        end
        default: begin
          rk_valid <= 1'b0;
          rk_last  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_inv_key_sched.sv
// tb_aes_128_inv_key_sched: directed and random checks of the reverse
// round-key stream against a GF(2^8)-derived forward expansion model.
module tb_aes_128_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key = '0;
  logic         start_valid = 1'b0;
  logic         rk_ready = 1'b1;
  logic         start_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         rk_valid;
  logic         busy;

  always #5 clk = ~clk;

  aes_128_inv_key_sched #(.NR(10), .SBOX_LAT(1)) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .rk(rk),
    .rk_round(rk_round),
    .rk_last(rk_last),
    .rk_valid(rk_valid),
    .rk_ready(rk_ready),
    .busy(busy)
  );

  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]   sbm [256];
  logic [127:0] ek  [11];
  logic [127:0] got [11];
  int first_cyc;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(a));
      sbm[a] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0] rc = 8'h01;
    ek[0] = k;
    {w0, w1, w2, w3} = k;
    for (int i = 1; i <= 10; i++) begin
      t = {w3[23:0], w3[31:24]};
      t = {sbm[t[31:24]], sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]]};
      w0 = w0 ^ t ^ {rc, 24'h0};
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      ek[i] = {w0, w1, w2, w3};
      rc = xt(rc);
    end
  endtask

  task automatic start(input logic [127:0] k);
    expand(k);
    @(negedge clk);
    chk("start_ready", 128'(start_ready), 128'd1);
    key = k;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    key = ~k;
  endtask

  task automatic drain(input int stall_rnd, input int stall_n,
                       input int stop_rnd, input bit chk_gap);
    int nxt = 10;
    int cyc = 0;
    int last = 0;
    first_cyc = -1;
    while (nxt >= 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        chk("fwd_busy", 128'(busy), 128'd1);
        chk("fwd_sready", 128'(start_ready), 128'd0);
      end
      if (rk_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        else if (chk_gap) chk("gap", 128'(cyc - last), 128'd3);
        if (nxt == stop_rnd) begin
          rk_ready = 1'b0;
          chk("stop_round", 128'(rk_round), 128'(nxt));
          return;
        end
        if (nxt == stall_rnd) begin
          rk_ready = 1'b0;
          repeat (stall_n) begin
            @(negedge clk);
            cyc++;
            chk("hold_rk", rk, ek[nxt]);
            chk("hold_round", 128'(rk_round), 128'(nxt));
            chk("hold_valid", 128'(rk_valid), 128'd1);
          end
          rk_ready = 1'b1;
        end
        chk("rk", rk, ek[nxt]);
        chk("rk_round", 128'(rk_round), 128'(nxt));
        chk("rk_last", 128'(rk_last), 128'(nxt == 0));
        chk("emit_sready", 128'(start_ready), 128'd0);
        got[nxt] = rk;
        last = cyc;
        nxt--;
      end
    end
    chk("drain_done", 128'(nxt < 0), 128'd1);
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("idle_busy", 128'(busy), 128'd0);
    chk("idle_sready", 128'(start_ready), 128'd1);
    chk("idle_valid", 128'(rk_valid), 128'd0);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_valid"}, 128'(rk_valid), 128'd0);
    chk({tag, "_rk"}, rk, 128'd0);
    chk({tag, "_round"}, 128'(rk_round), 128'd0);
    chk({tag, "_last"}, 128'(rk_last), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] ka, kb;
    build_sbox();
    #1;
    zero_chk("reset");
    chk("reset_sready", 128'(start_ready), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_sready", 128'(start_ready), 128'd1);

    // FIPS-197 key, full stream with timing
    start(FIPS);
    drain(-1, 0, -1, 1'b1);
    chk("first_latency", 128'(first_cyc), 128'd21);
    chk("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r0", got[0], FIPS);
    idle_chk();

    // All-zero key
    start(128'h0);
    drain(-1, 0, -1, 1'b1);
    chk("zero_r10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("zero_r0", got[0], 128'h0);
    idle_chk();

    // Backpressure at round 6
    start(FIPS);
    drain(6, 7, -1, 1'b0);
    chk("bp_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("bp_r0", got[0], FIPS);
    idle_chk();

    // start_valid held high with a changing key
    ka = 128'h000102030405060708090a0b0c0d0e0f;
    kb = 128'hffeeddccbbaa99887766554433221100;
    expand(ka);
    @(negedge clk);
    key = ka;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    key = kb;
    drain(-1, 0, -1, 1'b0);
    chk("hold_r10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    @(negedge clk);
    chk("b2b_sready", 128'(start_ready), 128'd1);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    expand(kb);
    drain(-1, 0, -1, 1'b0);
    chk("b2b_r0", got[0], kb);
    idle_chk();

    // Reset mid-forward at E9
    start(FIPS);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    zero_chk("rst_fwd");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fwd_sready", 128'(start_ready), 128'd1);

    // Reset mid-emit at round 4
    start(128'h0);
    drain(-1, 0, 4, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    zero_chk("rst_emit");
    @(negedge clk);
    rst = 1'b0;
    rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_emit_quiet", 128'(rk_valid), 128'd0);
    start(FIPS);
    drain(-1, 0, -1, 1'b1);
    chk("fresh_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    idle_chk();

    // Random keys against the forward model
    for (int i = 0; i < 100; i++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      start(ka);
      drain(-1, 0, -1, 1'b0);
    end
    idle_chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
